// File: rtl/mcu_spi_slave_pkg.sv
// Shared definitions for the MCU SPI slave: target indices and the transaction FSM encoding.
package mcu_spi_slave_pkg;

  typedef enum logic [1:0] {
    TGT_SYSCTRL = 2'd0,
    TGT_HID     = 2'd1,
    TGT_OSD     = 2'd2,
    TGT_SDC     = 2'd3
  } tgt_e;

  typedef enum logic [1:0] {
    StIdle,
    StTarget,
    StPayload,
    StIgnore
  } state_e;

endpackage

// File: rtl/spi_sync.sv
// Multi-stage synchronizer for {ss, sck, din} with edge detection on SCK and SS.
module spi_sync #(
  parameter int unsigned Stages = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] async_i,     // {ss, sck, din}
  output logic       ss_o,
  output logic       din_o,
  output logic       sck_rise_o,
  output logic       sck_fall_o,
  output logic       ss_fall_o
);

  logic [2:0] chain_q [Stages];
  logic [1:0] prev_q;             // {ss, sck} one sample behind the synchronized value

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(Stages); i++) chain_q[i] <= '0;
      prev_q <= '0;
    end else begin
      chain_q[0] <= async_i;
      for (int i = 1; i < int'(Stages); i++) chain_q[i] <= chain_q[i-1];
      prev_q <= chain_q[Stages-1][2:1];
    end
  end

  always_comb begin
    ss_o       = chain_q[Stages-1][2];
    din_o      = chain_q[Stages-1][0];
    sck_rise_o = chain_q[Stages-1][1] & ~prev_q[0];
    sck_fall_o = ~chain_q[Stages-1][1] & prev_q[0];
    ss_fall_o  = ~chain_q[Stages-1][2] & prev_q[1];
  end

endmodule

// File: rtl/mcu_spi_slave.sv
// MCU-facing SPI mode-0 slave: the first byte of a frame selects a target, later bytes are
// strobed to it, and the target's data_out is shifted back on MISO.
module mcu_spi_slave
  import mcu_spi_slave_pkg::*;
#(
  parameter int unsigned NUM_TARGETS = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     spi_io_ss,
  input  logic                     spi_io_clk,
  input  logic                     spi_io_din,
  output logic                     spi_io_dout,
  output logic [NUM_TARGETS-1:0]   target_strobe,
  output logic                     target_start,
  output logic [7:0]               target_data,
  input  logic [8*NUM_TARGETS-1:0] target_dout
);

  localparam int unsigned IdxW = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;

  logic ss_s, din_s, sck_rise, sck_fall, ss_fall;

  spi_sync #(
    .Stages(SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .reset_n   (reset_n),
    .async_i   ({spi_io_ss, spi_io_clk, spi_io_din}),
    .ss_o      (ss_s),
    .din_o     (din_s),
    .sck_rise_o(sck_rise),
    .sck_fall_o(sck_fall),
    .ss_fall_o (ss_fall)
  );

  state_e                 state_q, state_d;
  logic [2:0]             cnt_q, cnt_d;
  logic [6:0]             rx_q, rx_d;
  logic [7:0]             tx_q, tx_d;
  logic                   dout_q, dout_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic                   first_q, first_d;
  logic [NUM_TARGETS-1:0] strobe_q, strobe_d;
  logic                   start_q, start_d;
  logic [7:0]             data_q, data_d;
  logic [7:0]             rx_byte, tgt_byte;
  logic                   byte_done;

  always_comb begin
    rx_byte   = {rx_q, din_s};
    byte_done = sck_rise && (cnt_q == 3'd7);
    tgt_byte  = target_dout[idx_q*8 +: 8];

    state_d  = state_q;
    cnt_d    = cnt_q;
    rx_d     = rx_q;
    tx_d     = tx_q;
    dout_d   = dout_q;
    idx_d    = idx_q;
    first_d  = first_q;
    strobe_d = '0;
    start_d  = start_q;
    data_d   = data_q;

    // A deasserted chip select overrides everything, including a byte completing this cycle.
    if (ss_s) begin
      state_d = StIdle;
      cnt_d   = 3'd0;
      tx_d    = 8'h00;
      dout_d  = 1'b0;
    end else if (state_q == StIdle) begin
      if (ss_fall) begin
        state_d = StTarget;
        cnt_d   = 3'd0;
      end
    end else begin
      if (sck_rise) begin
        rx_d  = rx_byte[6:0];
        cnt_d = cnt_q + 3'd1;
      end
      if (byte_done) begin
        case (state_q)
          StTarget: begin
            if (32'(rx_byte) < NUM_TARGETS) begin
              idx_d   = rx_byte[IdxW-1:0];
              first_d = 1'b1;
              state_d = StPayload;
            end else begin
              state_d = StIgnore;
            end
          end
          StPayload: begin
            strobe_d[idx_q] = 1'b1;
            start_d         = first_q;
            data_d          = rx_byte;
            first_d         = 1'b0;
          end
          default: ;
        endcase
      end
      if (sck_fall) begin
        if (cnt_q == 3'd0) tx_d = (state_q == StPayload) ? tgt_byte : 8'h00;
        else               tx_d = {tx_q[6:0], 1'b0};
        dout_d = tx_d[7];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      cnt_q    <= 3'd0;
      rx_q     <= '0;
      tx_q     <= 8'h00;
      dout_q   <= 1'b0;
      idx_q    <= '0;
      first_q  <= 1'b0;
      strobe_q <= '0;
      start_q  <= 1'b0;
      data_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rx_q     <= rx_d;
      tx_q     <= tx_d;
      dout_q   <= dout_d;
      idx_q    <= idx_d;
      first_q  <= first_d;
      strobe_q <= strobe_d;
      start_q  <= start_d;
      data_q   <= data_d;
    end
  end

  assign spi_io_dout   = dout_q;
  assign target_strobe = strobe_q;
  assign target_start  = start_q;
  assign target_data   = data_q;

endmodule

// File: tb/tb_mcu_spi_slave.sv
// Scoreboard bench for mcu_spi_slave: directed SPI frames, emulated targets, queued expectations.
module tb_mcu_spi_slave;
  import mcu_spi_slave_pkg::*;

  localparam int NT = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          ss = 1'b1;
  logic          sck = 1'b0;
  logic          din = 1'b0;
  logic          dout;
  logic [NT-1:0] strobe;
  logic          start;
  logic [7:0]    data;
  logic [8*NT-1:0] tdout;

  always #5 clk = ~clk;

  mcu_spi_slave #(
    .NUM_TARGETS(NT),
    .SYNC_STAGES(2)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .spi_io_ss    (ss),
    .spi_io_clk   (sck),
    .spi_io_din   (din),
    .spi_io_dout  (dout),
    .target_strobe(strobe),
    .target_start (start),
    .target_data  (data),
    .target_dout  (tdout)
  );

  // Emulated targets: sysctrl answers byte b with b+0x42; the others return constants.
  logic [7:0] sys_resp;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) sys_resp <= 8'h5C;
    else if (strobe[TGT_SYSCTRL]) sys_resp <= data + 8'h42;
  end
  assign tdout = {8'h3C, 8'hA5, 8'h96, sys_resp};

  typedef struct packed {
    logic [NT-1:0] stb;
    logic          st;
    logic [7:0]    dat;
  } strobe_t;

  strobe_t    exp_q[$];
  logic [7:0] miso_exp_q[$];
  logic [7:0] miso_got_q[$];
  int errors = 0;
  int checks = 0;
  int half = 6;
  logic [7:0] pred;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per strobe pulse and per captured MISO byte.
  always @(negedge clk) begin
    strobe_t    e;
    logic [7:0] g, x;
    if (strobe !== '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", {19'd0, strobe, start, data}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("strobe", 32'(strobe), 32'(e.stb));
        check("start", 32'(start), 32'(e.st));
        check("data", 32'(data), 32'(e.dat));
      end
    end
    if (miso_got_q.size() != 0) begin
      g = miso_got_q.pop_front();
      if (miso_exp_q.size() == 0) begin
        check("unexpected_miso", 32'(g), 32'hFFFF_FFFF);
      end else begin
        x = miso_exp_q.pop_front();
        check("miso", 32'(g), 32'(x));
      end
    end
  end

  task automatic exp_strobe(input int t, input logic st, input logic [7:0] d);
    strobe_t e;
    e.stb = NT'(1) << t;
    e.st  = st;
    e.dat = d;
    exp_q.push_back(e);
  endtask

  task automatic sck_bit(input logic b, output logic m);
    din = b;
    repeat (half) @(negedge clk);
    m   = dout;
    sck = 1'b1;
    repeat (half) @(negedge clk);
    sck = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [7:0] exp_miso);
    logic [7:0] m;
    logic       mb;
    miso_exp_q.push_back(exp_miso);
    for (int i = 7; i >= 0; i--) begin
      sck_bit(b[i], mb);
      m[i] = mb;
    end
    miso_got_q.push_back(m);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    logic mb;
    for (int i = 0; i < n; i++) sck_bit(b[7-i], mb);
  endtask

  task automatic ss_low();
    @(negedge clk);
    ss = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic ss_high();
    repeat (half) @(negedge clk);
    ss = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    repeat (3) @(negedge clk);
    check("reset_dout", 32'(dout), 32'd0);
    check("reset_strobe", 32'(strobe), 32'd0);
    check("reset_start", 32'(start), 32'd0);
    check("reset_data", 32'(data), 32'd0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // Sysctrl frame: MISO 00, 5C, 42, EC.
    ss_low();
    send_byte(8'h00, 8'h00);
    exp_strobe(TGT_SYSCTRL, 1'b1, 8'h00);
    send_byte(8'h00, 8'h5C);
    exp_strobe(TGT_SYSCTRL, 1'b0, 8'hAA);
    send_byte(8'hAA, 8'h42);
    exp_strobe(TGT_SYSCTRL, 1'b0, 8'hAA);
    send_byte(8'hAA, 8'hEC);
    ss_high();

    // OSD frame; start/data hold after the last strobe.
    ss_low();
    send_byte(8'h02, 8'h00);
    exp_strobe(TGT_OSD, 1'b1, 8'h05);
    send_byte(8'h05, 8'hA5);
    exp_strobe(TGT_OSD, 1'b0, 8'h77);
    send_byte(8'h77, 8'hA5);
    ss_high();
    check("hold_start", 32'(start), 32'd0);
    check("hold_data", 32'(data), 32'h77);

    // Invalid target: no strobes, MISO zero.
    ss_low();
    send_byte(8'h09, 8'h00);
    send_byte(8'h00, 8'h00);
    send_byte(8'hFF, 8'h00);
    send_byte(8'h5A, 8'h00);
    ss_high();

    // Partial byte aborted by ss, then a fresh HID frame.
    ss_low();
    send_byte(8'h03, 8'h00);
    exp_strobe(TGT_SDC, 1'b1, 8'h10);
    send_byte(8'h10, 8'h3C);
    send_bits(8'hE7, 5);
    ss_high();
    ss_low();
    send_byte(8'h01, 8'h00);
    exp_strobe(TGT_HID, 1'b1, 8'h03);
    send_byte(8'h03, 8'h96);
    ss_high();

    // Reset mid-byte with ss held low.
    ss_low();
    send_byte(8'h01, 8'h00);
    exp_strobe(TGT_HID, 1'b1, 8'h44);
    send_byte(8'h44, 8'h96);
    send_bits(8'hC3, 3);
    reset_n = 1'b0;
    #1;
    check("midrst_dout", 32'(dout), 32'd0);
    check("midrst_strobe", 32'(strobe), 32'd0);
    check("midrst_start", 32'(start), 32'd0);
    check("midrst_data", 32'(data), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    send_byte(8'h01, 8'h00);
    send_byte(8'h55, 8'h00);
    ss_high();
    ss_low();
    send_byte(8'h00, 8'h00);
    exp_strobe(TGT_SYSCTRL, 1'b1, 8'h12);
    send_byte(8'h12, 8'h5C);
    ss_high();
    pred = 8'h54;

    // Minimum SCK timing, 256 random sysctrl payload bytes.
    half = 4;
    ss_low();
    send_byte(8'h00, 8'h00);
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom);
      exp_strobe(TGT_SYSCTRL, (i == 0), b);
      send_byte(b, pred);
      pred = b + 8'h42;
    end
    ss_high();

    repeat (20) @(negedge clk);
    check("strobe_queue_drained", 32'(exp_q.size()), 32'd0);
    check("miso_queue_drained", 32'(miso_exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
